// File: rtl/sync_ram_be_clr.sv
// sync_ram_be_clr: single-port RAM with byte enables, registered read and a zero-fill clear engine
module sync_ram_be_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr_req,
  output logic                busy,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                rd_err
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic busy_q, busy_d, dv_q, dv_d, err_q, err_d;
  logic in_rng, wr_en, clr_en;
  logic [DATA_W-1:0] mem [DEPTH];
  assign in_rng = 32'(addr) < DEPTH;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    if (state_q == CLEAR) begin
      clr_en = 1'b1;
      ptr_d  = ptr_q + 1'b1;
      state_d = (ptr_q == LAST) ? IDLE : CLEAR;
      busy_d  = ptr_q != LAST;
    end else if (clr_req) begin
      state_d = CLEAR;
      ptr_d   = '0;
      busy_d  = 1'b1;
    end else begin
      wr_en = we && in_rng;
      // out-of-range reads return zero and are never aliased onto real words
      if (re) begin
        dv_d   = 1'b1;
        err_d  = !in_rng;
        dout_d = in_rng ? mem[addr] : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end
  // the array is left untouched while reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && clr_en) mem[ptr_q] <= '0;
    else if (rst_n && wr_en)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
  end
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign rd_err     = err_q;
endmodule
